ft60x_bus_controller: RTL and testbench

- Parametrised successor to the single-width FT601 controller. Drives the FT600 (16-bit) or FT601 (32-bit) synchronous 245-FIFO bus.
- Adds valid/ready streams toward the peripheral arbiter, backpressure with a skid buffer, bounded bursts with fair read/write alternation, and a configurable bus-turnaround gap.
- Sits between the FT60x pins (tristate muxing in the top level) and the peripheral arbiter.

---
 rtl/ft60x_bus_controller_if.sv | 47 ++++
 rtl/ft60x_bus_controller.sv | 152 +++++++++++++++
 tb/tb_ft60x_bus_controller.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft60x_bus_controller_if.sv
// FT60x pin-side and peripheral-stream signals of ft60x_bus_controller, bundled for port hookup.
// master = controller side, slave = pins/peripheral side.
interface ft60x_bus_controller_if #(
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              usb_rx_empty;
    logic              usb_tx_full;
    logic              usb_wren_l;
    logic              usb_rden_l;
    logic              usb_outen_l;
    logic              usb_rst_l;
    logic [DATA_W-1:0] usb_data_in;
    logic [DATA_W-1:0] usb_data_out;
    logic              usb_data_tri;
    logic [BE_W-1:0]   be_in;
    logic [BE_W-1:0]   be_out;
    logic              be_tri;
    logic              periph_ready;
    logic [DATA_W-1:0] rx_data;
    logic [BE_W-1:0]   rx_be;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic [BE_W-1:0]   tx_be;
    logic              tx_valid;
    logic              tx_ready;
    logic [31:0]       stat_rx_words;
    logic [31:0]       stat_tx_words;

    modport master (
        input  usb_rx_empty, usb_tx_full, usb_data_in, be_in, periph_ready,
               rx_ready, tx_data, tx_be, tx_valid,
        output usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l, usb_data_out,
               usb_data_tri, be_out, be_tri, rx_data, rx_be, rx_valid,
               tx_ready, stat_rx_words, stat_tx_words
    );

    modport slave (
        output usb_rx_empty, usb_tx_full, usb_data_in, be_in, periph_ready,
               rx_ready, tx_data, tx_be, tx_valid,
        input  usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l, usb_data_out,
               usb_data_tri, be_out, be_tri, rx_data, rx_be, rx_valid,
               tx_ready, stat_rx_words, stat_tx_words
    );
endinterface

// File: rtl/ft60x_bus_controller.sv
// FT600/FT601 245-FIFO controller: rx word valid 1 cycle after capture, optional FT60X_STATS_EN counters.
// Backpressure: a 1-entry rx skid buffer holds off usb_rden_l; tx_ready is the write strobe itself.
module ft60x_bus_controller #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 64,
    parameter int TURN_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    ft60x_bus_controller_if.master  bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [15:0] BURST_MAX = 16'(MAX_BURST);
    localparam logic [2:0]  TURN_LAST = 3'(TURN_CYC - 1);

    typedef enum logic [2:0] {IDLE, RD_OE, RD, TURN, WR} state_t;

    state_t            state_q;
    logic [15:0]       burst_q, burst_d;
    logic [2:0]        turn_q;
    logic              wr_prio_q;
    logic              usb_rst_l_q;
    logic              rx_vld_q, skid_vld_q;
    logic [DATA_W-1:0] rx_dat_q, skid_dat_q;
    logic [BE_W-1:0]   rx_be_q, skid_be_q;

    logic burst_full, rx_pend, tx_pend, rd_go, wr_go;

    assign burst_full = (burst_q == BURST_MAX);
    assign rx_pend    = !bus.usb_rx_empty;
    assign tx_pend    = bus.tx_valid && !bus.usb_tx_full;

    // A capped burst stops strobing while the other direction waits, so no burst exceeds MAX_BURST.
    assign rd_go = !rst && (state_q == RD) && rx_pend && !skid_vld_q && !(burst_full && tx_pend);
    assign wr_go = !rst && (state_q == WR) && tx_pend && !(burst_full && rx_pend);

    assign bus.usb_rden_l   = !rd_go;
    assign bus.usb_wren_l   = !wr_go;
    assign bus.tx_ready     = wr_go;
    assign bus.usb_outen_l  = !((state_q == RD_OE) || (state_q == RD));
    assign bus.usb_data_tri = (state_q != WR);
    assign bus.be_tri       = (state_q != WR);
    assign bus.usb_data_out = bus.tx_data;
    assign bus.be_out       = bus.tx_be;
    assign bus.usb_rst_l    = usb_rst_l_q;
    assign bus.rx_data      = rx_dat_q;
    assign bus.rx_be        = rx_be_q;
    assign bus.rx_valid     = rx_vld_q;

    always_comb begin
        burst_d = burst_q;
        if ((state_q != RD) && (state_q != WR))
            burst_d = '0;
        else if ((rd_go || wr_go) && !burst_full)
            burst_d = burst_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            turn_q      <= '0;
            wr_prio_q   <= 1'b0;
            usb_rst_l_q <= 1'b0;
        end else begin
            usb_rst_l_q <= 1'b1;
            burst_q     <= burst_d;
            case (state_q)
                IDLE: begin
                    turn_q <= '0;
                    if (bus.periph_ready) begin
                        // After a read burst hit its cap, the write side wins the next tie.
                        if (rx_pend && !skid_vld_q && !(wr_prio_q && tx_pend))
                            state_q <= RD_OE;
                        else if (tx_pend)
                            state_q <= TURN;
                    end
                end
                RD_OE: state_q <= bus.periph_ready ? RD : IDLE;
                RD: begin
                    if (!bus.periph_ready || !rx_pend || (burst_full && tx_pend)) begin
                        state_q   <= IDLE;
                        wr_prio_q <= burst_full && tx_pend;
                    end
                end
                TURN: begin
                    if (!bus.periph_ready)
                        state_q <= IDLE;
                    else if (turn_q == TURN_LAST)
                        state_q <= WR;
                    else
                        turn_q <= turn_q + 3'd1;
                end
                WR: begin
                    wr_prio_q <= 1'b0;
                    if (!bus.periph_ready || !tx_pend || (burst_full && rx_pend))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output register refills from the skid entry first so word order is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_vld_q   <= 1'b0;
            skid_vld_q <= 1'b0;
            rx_dat_q   <= '0;
            rx_be_q    <= '0;
            skid_dat_q <= '0;
            skid_be_q  <= '0;
        end else if (!rx_vld_q || bus.rx_ready) begin
            if (skid_vld_q) begin
                rx_dat_q   <= skid_dat_q;
                rx_be_q    <= skid_be_q;
                rx_vld_q   <= 1'b1;
                skid_vld_q <= 1'b0;
            end else if (rd_go) begin
                rx_dat_q <= bus.usb_data_in;
                rx_be_q  <= bus.be_in;
                rx_vld_q <= 1'b1;
            end else begin
                rx_vld_q <= 1'b0;
            end
        end else if (rd_go) begin
            skid_dat_q <= bus.usb_data_in;
            skid_be_q  <= bus.be_in;
            skid_vld_q <= 1'b1;
        end
    end

`ifdef FT60X_STATS_EN
    logic [31:0] stat_rx_q, stat_tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rx_q <= '0;
            stat_tx_q <= '0;
        end else begin
            if (rd_go) stat_rx_q <= stat_rx_q + 32'd1;
            if (wr_go) stat_tx_q <= stat_tx_q + 32'd1;
        end
    end

    assign bus.stat_rx_words = stat_rx_q;
    assign bus.stat_tx_words = stat_tx_q;
`else
    assign bus.stat_rx_words = '0;
    assign bus.stat_tx_words = '0;
`endif
endmodule

// File: tb/tb_ft60x_bus_controller.sv
// Directed bench for ft60x_bus_controller with an FT60x FIFO model and rx/tx scoreboards.
module tb_ft60x_bus_controller;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXB = 8;
    localparam int TC   = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [BW-1:0] be;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ft60x_bus_controller_if #(.DATA_W(DW)) bus ();

    ft60x_bus_controller #(.DATA_W(DW), .MAX_BURST(MAXB), .TURN_CYC(TC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int failures = 0;

    word_t host_q[$], exp_rx_q[$], src_q[$], exp_tx_q[$];
    logic  rst_v = 1'b1, rx_rdy_v = 1'b1, tx_full_v = 1'b0;
    bit    rd_x = 0, tx_acc = 0;
    int    cyc = 0, n_rx = 0, n_wr = 0, n_rd = 0, tot_rd = 0, tot_wr = 0;
    int    t_oe = -1, t_rd = -1, vrun = 0, vrun_max = 0, wrun = 0, wrun_max = 0;
    int    rden_hold = 0, rel = 0, gap_cnt = 0, gap_res = -1;
    bit    oe_seen = 0, gap_arm = 0;
    logic [BW-1:0] last_be = '0;
    int    cur_dir = 0, run_len = 0;
    int    run_len_q[$], run_dir_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rx(input logic [DW-1:0] d, input logic [BW-1:0] be);
        word_t w;
        w.d = d; w.be = be;
        host_q.push_back(w);
        exp_rx_q.push_back(w);
    endtask

    task automatic push_tx(input logic [DW-1:0] d, input logic [BW-1:0] be);
        word_t w;
        w.d = d; w.be = be;
        src_q.push_back(w);
        exp_tx_q.push_back(w);
    endtask

    task automatic note_dir(input int d);
        if (d != cur_dir) begin
            if (cur_dir != 0) begin
                run_len_q.push_back(run_len);
                run_dir_q.push_back(cur_dir);
            end
            cur_dir = d;
            run_len = 1;
        end else begin
            run_len++;
        end
    endtask

    task automatic monitor();
        word_t e;
        chk("contention", {63'd0, (!bus.usb_outen_l && !bus.usb_data_tri)}, 64'd0);
        chk("wren_vs_tx_ready", {63'd0, bus.usb_wren_l}, {63'd0, !bus.tx_ready});
        rd_x   = !bus.usb_rden_l && !bus.usb_rx_empty;
        tx_acc = bus.tx_valid && bus.tx_ready;
        if (!bus.usb_wren_l) begin
            if (exp_tx_q.size() == 0) chk("tx_unexpected", 64'd1, 64'd0);
            else begin
                e = exp_tx_q.pop_front();
                chk("tx_word", {28'd0, bus.usb_data_out, bus.be_out}, {28'd0, e.d, e.be});
            end
            n_wr++; tot_wr++; wrun++;
            if (wrun > wrun_max) wrun_max = wrun;
            last_be = bus.be_out;
            note_dir(2);
        end else wrun = 0;
        if (rd_x) begin
            n_rd++; tot_rd++;
            if (t_rd < 0) t_rd = cyc;
            note_dir(1);
        end
        if (!rst_v && bus.rx_valid && bus.rx_ready) begin
            if (exp_rx_q.size() == 0) chk("rx_unexpected", 64'd1, 64'd0);
            else begin
                e = exp_rx_q.pop_front();
                chk("rx_word", {28'd0, bus.rx_data, bus.rx_be}, {28'd0, e.d, e.be});
            end
            n_rx++;
        end
        if (bus.rx_valid) begin
            vrun++;
            if (vrun > vrun_max) vrun_max = vrun;
        end else vrun = 0;
        if (!bus.usb_outen_l && t_oe < 0) t_oe = cyc;
        if (!bus.usb_outen_l && !bus.usb_rx_empty && bus.usb_rden_l) rden_hold++;
        if (!bus.usb_outen_l) begin
            oe_seen = 1; rel = 0;
        end else if (bus.usb_data_tri) rel++;
        else if (oe_seen) begin
            chk("turn_gap", {63'd0, (rel >= TC)}, 64'd1);
            oe_seen = 0;
        end
        if (gap_arm) begin
            if (!bus.usb_wren_l) begin
                gap_res = gap_cnt; gap_arm = 0;
            end else gap_cnt++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rd_x) void'(host_q.pop_front());
        if (tx_acc) void'(src_q.pop_front());
        rd_x = 0; tx_acc = 0;
        rst = rst_v;
        bus.rx_ready    = rx_rdy_v;
        bus.usb_tx_full = tx_full_v;
        bus.usb_rx_empty = (host_q.size() == 0);
        bus.usb_data_in  = (host_q.size() != 0) ? host_q[0].d  : '0;
        bus.be_in        = (host_q.size() != 0) ? host_q[0].be : '0;
        bus.tx_valid     = (src_q.size() != 0);
        bus.tx_data      = (src_q.size() != 0) ? src_q[0].d  : '0;
        bus.tx_be        = (src_q.size() != 0) ? src_q[0].be : '0;
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic phase_reset();
        n_rx = 0; n_wr = 0; n_rd = 0; t_oe = -1; t_rd = -1;
        vrun_max = 0; wrun_max = 0; rden_hold = 0;
        cur_dir = 0; run_len = 0;
        run_len_q.delete(); run_dir_q.delete();
    endtask

    initial begin
        bus.usb_rx_empty = 1'b1; bus.usb_tx_full = 1'b0; bus.usb_data_in = '0;
        bus.be_in = '0; bus.periph_ready = 1'b1; bus.rx_ready = 1'b1;
        bus.tx_data = '0; bus.tx_be = '0; bus.tx_valid = 1'b0;

        // Reset held 3 cycles, then released.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_l_in_reset", {63'd0, bus.usb_rst_l}, 64'd0);
        end
        chk("rst_strobes", {61'd0, bus.usb_wren_l, bus.usb_rden_l, bus.usb_outen_l}, 64'd7);
        chk("rst_tri", {62'd0, bus.usb_data_tri, bus.be_tri}, 64'd3);
        chk("rst_rx_valid", {63'd0, bus.rx_valid}, 64'd0);
        chk("rst_tx_ready", {63'd0, bus.tx_ready}, 64'd0);
        chk("rst_stats", {bus.stat_rx_words, bus.stat_tx_words}, 64'd0);
        rst_v = 1'b0;
        cycle();
        chk("rst_l_release_cycle", {63'd0, bus.usb_rst_l}, 64'd0);
        cycle();
        chk("rst_l_after_release", {63'd0, bus.usb_rst_l}, 64'd1);

        // Four words host->peripheral, sink always ready.
        phase_reset();
        push_rx(32'h11111111, 4'hF); push_rx(32'h22222222, 4'hF);
        push_rx(32'h33333333, 4'hF); push_rx(32'h44444444, 4'hF);
        for (int i = 0; i < 60 && n_rx < 4; i++) cycle();
        chk("rd4_done", {63'd0, (n_rx == 4)}, 64'd1);
        repeat (3) cycle();
        chk("rd4_oe_lead", 64'(t_rd - t_oe), 64'd1);
        chk("rd4_valid_run", 64'(vrun_max), 64'd4);
        chk("rd4_rden_hold", 64'(rden_hold), 64'd1);
        chk("rd4_sb_empty", 64'(exp_rx_q.size()), 64'd0);

        // Same four words with a 3-cycle sink stall after the first word.
        phase_reset();
        push_rx(32'h11111111, 4'hF); push_rx(32'h22222222, 4'hF);
        push_rx(32'h33333333, 4'hF); push_rx(32'h44444444, 4'hF);
        for (int i = 0; i < 60 && n_rx < 1; i++) cycle();
        rx_rdy_v = 1'b0;
        repeat (3) cycle();
        rx_rdy_v = 1'b1;
        for (int i = 0; i < 60 && n_rx < 4; i++) cycle();
        repeat (3) cycle();
        chk("stall_done", 64'(n_rx), 64'd4);
        chk("stall_rden_held", {63'd0, (rden_hold > 1)}, 64'd1);
        chk("stall_sb_empty", 64'(exp_rx_q.size() + host_q.size()), 64'd0);

        // Five-word write packet with a partial final byte enable.
        phase_reset();
        push_tx(32'hA0000001, 4'hF); push_tx(32'hA0000002, 4'hF);
        push_tx(32'hA0000003, 4'hF); push_tx(32'hA0000004, 4'hF);
        push_tx(32'hA0000005, 4'h3);
        gap_cnt = 0; gap_res = -1; gap_arm = 1;
        for (int i = 0; i < 60 && n_wr < 5; i++) cycle();
        repeat (3) cycle();
        chk("wr5_count", 64'(n_wr), 64'd5);
        chk("wr5_run", 64'(wrun_max), 64'd5);
        chk("wr5_gap", 64'(gap_res), 64'(TC + 1));
        chk("wr5_last_be", {60'd0, last_be}, 64'h3);
        chk("wr5_sb_empty", 64'(exp_tx_q.size()), 64'd0);

        // Both directions continuously pending: fair capped bursts.
        phase_reset();
        for (int i = 0; i < 24; i++) begin
            push_rx(32'hC000_0000 + 32'(i), 4'hF);
            push_tx(32'hD000_0000 + 32'(i), 4'hF);
        end
        for (int i = 0; i < 600 && (exp_rx_q.size() + exp_tx_q.size()) != 0; i++) cycle();
        repeat (3) cycle();
        if (cur_dir != 0) begin
            run_len_q.push_back(run_len);
            run_dir_q.push_back(cur_dir);
        end
        chk("alt_drained", 64'(exp_rx_q.size() + exp_tx_q.size()), 64'd0);
        chk("alt_runs", 64'(run_len_q.size()), 64'd6);
        for (int i = 0; i < run_len_q.size(); i++) begin
            chk("alt_run_len", 64'(run_len_q[i]), 64'(MAXB));
            chk("alt_run_dir", 64'(run_dir_q[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

`ifdef FT60X_STATS_EN
        chk("stat_rx", {32'd0, bus.stat_rx_words}, 64'(tot_rd));
        chk("stat_tx", {32'd0, bus.stat_tx_words}, 64'(tot_wr));
`else
        chk("stat_rx_off", {32'd0, bus.stat_rx_words}, 64'd0);
        chk("stat_tx_off", {32'd0, bus.stat_tx_words}, 64'd0);
`endif

        // FT60x goes full mid-write.
        phase_reset();
        for (int i = 0; i < 6; i++) push_tx(32'hE000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 60 && n_wr < 2; i++) cycle();
        tx_full_v = 1'b1;
        cycle();
        chk("full_wren_high", {63'd0, bus.usb_wren_l}, 64'd1);
        chk("full_tx_ready_low", {63'd0, bus.tx_ready}, 64'd0);
        tx_full_v = 1'b0;
        for (int i = 0; i < 60 && exp_tx_q.size() != 0; i++) cycle();
        chk("full_resume_done", 64'(n_wr), 64'd6);

        // Reset asserted in the middle of a read burst.
        phase_reset();
        for (int i = 0; i < 6; i++) push_rx(32'hF000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 60 && n_rx < 2; i++) cycle();
        chk("midrst_reading", {63'd0, bus.usb_outen_l}, 64'd0);
        rst_v = 1'b1;
        cycle();
        chk("midrst_no_rden", {63'd0, bus.usb_rden_l}, 64'd1);
        cycle();
        chk("midrst_strobes", {61'd0, bus.usb_wren_l, bus.usb_rden_l, bus.usb_outen_l}, 64'd7);
        chk("midrst_tri", {62'd0, bus.usb_data_tri, bus.be_tri}, 64'd3);
        chk("midrst_rst_l", {63'd0, bus.usb_rst_l}, 64'd0);
        chk("midrst_rx_valid", {63'd0, bus.rx_valid}, 64'd0);
        chk("midrst_stats", {bus.stat_rx_words, bus.stat_tx_words}, 64'd0);
        host_q.delete();
        exp_rx_q.delete();
        rst_v = 1'b0;
        repeat (3) cycle();
        chk("post_rst_rst_l", {63'd0, bus.usb_rst_l}, 64'd1);
        chk("post_rst_idle", {63'd0, bus.usb_outen_l}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
